seq_divider: RTL
================

Name: seq_divider

Overview:
- Parametrised, handshaked, multi-cycle integer divider; next generation of the team's fixed 32-bit divider.
- Adds configurable width, per-operation signed/unsigned mode, divide-by-zero and signed-overflow flags, and valid/ready flow control on both sides.
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.
- Sits between a requesting datapath, such as the factorial/average blocks, and any consumer that may stall.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  divider can accept a request
- dividend  input  WIDTH  numerator, sampled on accept
- divisor  input  WIDTH  denominator, sampled on accept
- signed_mode  input  1  1 = two's-complement operation, 0 = unsigned; sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  result came from a zero divisor
- overflow  output  1  signed most-negative / -1 case

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - All internal registers 0.
  - Reset asserted mid-operation aborts the operation immediately; no result is ever produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on a rising edge with in_valid&in_ready; dividend, divisor and signed_mode are latched.
  - divisor==0 → go to DONE:
    - quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
    - out_valid high 1 edge after accept.
  - Otherwise → go to CALC:
    - Latch magnitudes: |dividend| and |divisor| when signed_mode, else raw values.
    - Latch sign flags: qneg = sign(dividend) XOR sign(divisor); rneg = sign(dividend). Both are 0 when unsigned.
    - Clear the partial remainder; iteration counter = WIDTH.
- CALC:
  - in_ready=0.
  - Each cycle shifts {partial remainder, dividend magnitude} left by 1.
  - Trial-subtracts the divisor magnitude using a WIDTH+1-bit subtractor.
  - If non-negative, it commits the difference and sets the quotient LSB to 1; otherwise it keeps the value and sets the LSB to 0.
  - Counter decrements.
  - After the WIDTH-th iteration, the next edge loads the output registers and enters DONE:
    - quotient = qneg ? -q : q
    - remainder = rneg ? -r : r
  - out_valid rises exactly WIDTH+1 edges after the accepting edge.
- Signed result convention:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - dividend = quotient*divisor + remainder always holds, modulo 2^WIDTH.
- Overflow:
  - Condition: signed_mode, dividend = 100…0, divisor = all ones.
  - quotient = 100…0 (falls out of the unsigned magnitude path naturally), remainder=0.
  - overflow=1.
  - Latency is the same as the normal path.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs hold stable until out_valid&out_ready on a rising edge, then go to IDLE.
  - out_valid drops on that edge; quotient/remainder/flags hold their last values.
- No pipelining:
  - A new request is never accepted in the same edge as the result handshake.
  - in_ready asserts the cycle after.
  - Throughput is at most one result per WIDTH+2 cycles.
- Input changes:
  - in_valid may drop without acceptance; no state effect.
  - Inputs are ignored outside IDLE.
- Unsigned mode treats operands with the MSB set as large positive values (e.g. 0xFFFFFFFF/2 = 0x7FFFFFFF r 1).

Test Plan:
- WIDTH=32, unsigned 100/7, out_ready=1 → out_valid 33 edges after accept, quotient=14, remainder=2, flags 0, in_ready high again 1 cycle after the handshake.
- Signed -7/2 (0xFFFFFFF9/0x00000002) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); also run unsigned 0xFFFFFFF9/2 → 0x7FFFFFFC r 1.
- 5/0, either mode → out_valid 1 edge after accept, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, overflow=0.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0, overflow=1, latency 33.
- Backpressure: 1000/10 with out_ready low for 10 cycles after out_valid → quotient=100, remainder=0 stable throughout, in_ready=0 and a concurrent in_valid is ignored; result consumed on the first out_ready high.
- Reset:
  - Assert rst_n=0 asynchronously 10 cycles into a CALC for 12345/3 → outputs zero immediately and in_ready=1 after release.
  - Then, with WIDTH=8, check that 200/3 gives 66 r 2 after 9 edges.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: handshaked radix-2 restoring integer divider producing one quotient
// bit per cycle, with per-request signed/unsigned mode and divide-by-zero/overflow flags.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q,     state_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;
  logic             ovf_q,       ovf_d;

  // Working registers: partial remainder, dividend magnitude that shifts left and
  // fills with quotient bits, divisor magnitude, sign fixups and pending flags.
  logic [WIDTH-1:0] prem_q,      prem_d;
  logic [WIDTH-1:0] qacc_q,      qacc_d;
  logic [WIDTH-1:0] dvs_q,       dvs_d;
  logic             qneg_q,      qneg_d;
  logic             rneg_q,      rneg_d;
  logic             dbz_pend_q,  dbz_pend_d;
  logic             ovf_pend_q,  ovf_pend_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign accept  = in_valid && in_ready_q;
  assign dvd_neg = signed_mode && dividend[WIDTH-1];
  assign dvs_neg = signed_mode && divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;

  // shifted < 2*divisor, so the WIDTH+1-bit difference has a reliable sign bit.
  assign shifted = {prem_q, qacc_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every *_d defaults to its *_q first, so no path can infer a latch.
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    prem_d      = prem_q;
    qacc_d      = qacc_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dbz_pend_d  = dbz_pend_q;
    ovf_pend_d  = ovf_pend_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = CALC;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            // Zero divisor skips the iterations: the result is staged so the
            // common load step in CALC publishes it one edge after accept.
            dbz_pend_d = 1'b1;
            ovf_pend_d = 1'b0;
            prem_d     = dividend;
            qacc_d     = '1;
            dvs_d      = '0;
            qneg_d     = 1'b0;
            rneg_d     = 1'b0;
            cnt_d      = '0;
          end else begin
            dbz_pend_d = 1'b0;
            ovf_pend_d = signed_mode && (dividend == MOST_NEG) && (divisor == '1);
            prem_d     = '0;
            qacc_d     = dvd_mag;
            dvs_d      = dvs_mag;
            qneg_d     = dvd_neg ^ dvs_neg;
            rneg_d     = dvd_neg;
            cnt_d      = CNT_W'(WIDTH);
          end
        end
      end

      CALC: begin
        if (cnt_q != '0) begin
          prem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          qacc_d = {qacc_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = qneg_q ? -qacc_q : qacc_q;
          remainder_d = rneg_q ? -prem_q : prem_q;
          dbz_d       = dbz_pend_q;
          ovf_d       = ovf_pend_q;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      prem_q      <= '0;
      qacc_q      <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      prem_q      <= prem_d;
      qacc_q      <= qacc_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dbz_pend_q  <= dbz_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
